fifo_rd_arb: RTL and testbench
==============================

FIFO_RD_ARB -- requirements
Module: fifo_rd_arb

Interface
REQ-001 The block SHALL have parameters (one per line: name, default, meaning):
- IDBITS, 2, requester index width; NREQ = 2**IDBITS requesters.
- DBITS, 16, FIFO data width.
- LBITS, 8, burst-length field width.
REQ-002 The block SHALL have one clock; reset is synchronous and active-low.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- rdclk, in, 1, the single clock; all logic on its rising edge.
- rst_n, in, 1, synchronous active-low reset.
- req, in, NREQ, per-requester burst request, level.
- req_len, in, NREQ*LBITS, burst length of requester i at bits [i*LBITS +: LBITS].
- gnt, out, NREQ, one-hot grant, held for the whole burst.
- fifo_rd_en, out, 1, FIFO read strobe.
- fifo_rd_data, in, DBITS, FIFO registered read data, valid 1 cycle after an accepted read.
- fifo_rd_empty, in, 1, FIFO empty flag.
- out_data, out, DBITS, routed read data.
- out_valid, out, 1, out_data/out_id/out_last qualifier.
- out_id, out, IDBITS, index of the requester owning the beat.
- out_last, out, 1, final beat of the burst.
- busy, out, 1, high in any state other than IDLE.

Function
REQ-004 The FSM SHALL have states IDLE, BURST and TAIL.
REQ-005 In IDLE with any req bit high, the block SHALL grant the round-robin winner, latch its req_len, and enter BURST on the next edge.
REQ-006 Round-robin search SHALL start at pointer rr_ptr, and rr_ptr SHALL become winner+1 (mod NREQ) at grant.
REQ-007 A latched length L SHALL yield L beats; L=0 SHALL be treated as L=1.
REQ-008 In BURST, fifo_rd_en SHALL equal ~fifo_rd_empty; an issue is counted when fifo_rd_en is high.
REQ-009 fifo_rd_en SHALL never be high while fifo_rd_empty is high.
REQ-010 When fifo_rd_empty is high during BURST, the block SHALL stall in BURST with no count change and no timeout.
REQ-011 On the issue of beat L, the FSM SHALL go to TAIL; TAIL SHALL last exactly 1 cycle and then return to IDLE.
REQ-012 fifo_rd_en SHALL be 0 in IDLE and TAIL.
REQ-013 out_valid SHALL be the registered issue strobe, high exactly 1 cycle after each issue.
REQ-014 out_data SHALL equal fifo_rd_data in the same cycle that out_valid is high.
REQ-015 out_id and out_last SHALL be registered alongside out_valid; out_last SHALL be high only with beat L.
REQ-016 gnt SHALL be registered, asserted from BURST entry through the end of TAIL, and 0 in IDLE.
REQ-017 Exactly one issue per cycle maximum; there is no downstream backpressure.
REQ-018 Deasserting req or changing req_len during a burst SHALL NOT affect the burst in progress.
REQ-019 Latency: req sampled in IDLE at cycle 0 -> gnt and first possible fifo_rd_en at cycle 1 -> first out_valid at cycle 2.
REQ-020 Minimum gap: the last issue at cycle k -> TAIL at k+1 -> IDLE at k+2 -> next grant at k+3.
REQ-021 The beat counter SHALL be LBITS+1 bits so that L=2**LBITS-1 never wraps.

Reset
REQ-022 When rst_n is sampled low, the block SHALL set state=IDLE and rr_ptr=0.
REQ-023 Reset SHALL drive gnt=0, fifo_rd_en=0, out_valid=0, out_last=0, out_id=0, out_data=0, busy=0, and beat count=0.
REQ-024 Reset mid-burst SHALL abort immediately with the same values and SHALL NOT emit any further out_valid.
REQ-025 Outputs SHALL be valid starting from the first edge with rst_n high.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Single burst: req=4'b0010, len1=3, FIFO non-empty -> gnt=0010 cycles 1-4; fifo_rd_en cycles 1-3; out_valid cycles 2-4 with out_id=1; out_last at cycle 4.
- Round-robin: req=4'b1111 held, all len=1 -> grants in order 0,1,2,3,0; 3-cycle grant spacing.
- Empty stall: len=4, fifo_rd_empty high for 2 cycles mid-burst -> fifo_rd_en=0 during the stall, exactly 4 out_valid total, out_last only on the 4th.
- Length zero: len=0 -> exactly 1 beat, out_last=1 on it.
- Maximum length: len=255 -> 255 beats, no counter wrap, single out_last.
- Reset mid-burst: rst_n low at beat 2 of 5 -> next edge all outputs 0 and state IDLE; after release, req=4'b0001 grants requester 0 (rr_ptr=0).

Source files
------------

// File: rtl/fifo_rd_arb.sv
// fifo_rd_arb: round-robin arbiter that grants one requester a burst of FIFO reads and routes the returned data to it.
module fifo_rd_arb #(
    parameter int IDBITS = 2,
    parameter int DBITS = 16,
    parameter int LBITS = 8,
    localparam int NREQ = 2**IDBITS
) (
    input  logic                  rdclk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*LBITS-1:0] req_len,
    output logic [NREQ-1:0]       gnt,
    output logic                  fifo_rd_en,
    input  logic [DBITS-1:0]      fifo_rd_data,
    input  logic                  fifo_rd_empty,
    output logic [DBITS-1:0]      out_data,
    output logic                  out_valid,
    output logic [IDBITS-1:0]     out_id,
    output logic                  out_last,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, BURST, TAIL} state_t;
    state_t state_q, state_d;
    logic [IDBITS-1:0] rr_q, rr_d, id_q, id_d, oid_q, win, idx;
    logic [LBITS:0] len_q, len_d, cnt_q, cnt_d;
    logic [LBITS-1:0] sel_len;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic found, issue, last, ov_q, ol_q;
    // search starts at the round-robin pointer and wraps through all requesters
    always_comb begin
        win = '0;
        found = 1'b0;
        idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = rr_q + IDBITS'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                win = idx;
            end
        end
    end
    assign sel_len = req_len[win*LBITS +: LBITS];
    assign issue = (state_q == BURST) && !fifo_rd_empty;
    assign last = (cnt_q + (LBITS+1)'(1)) == len_q;
    always_comb begin
        state_d = state_q;
        rr_d = rr_q;
        id_d = id_q;
        len_d = len_q;
        cnt_d = cnt_q;
        gnt_d = gnt_q;
        case (state_q)
            IDLE: if (found) begin
                state_d = BURST;
                rr_d = win + IDBITS'(1);
                id_d = win;
                len_d = (sel_len == '0) ? (LBITS+1)'(1) : {1'b0, sel_len};
                cnt_d = '0;
                gnt_d = NREQ'(1) << win;
            end
            BURST: if (issue) begin
                cnt_d = cnt_q + (LBITS+1)'(1);
                state_d = last ? TAIL : BURST;
            end
            TAIL: begin
                state_d = IDLE;
                gnt_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge rdclk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q <= '0;
            id_q <= '0;
            len_q <= '0;
            cnt_q <= '0;
            gnt_q <= '0;
            ov_q <= 1'b0;
            ol_q <= 1'b0;
            oid_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q <= rr_d;
            id_q <= id_d;
            len_q <= len_d;
            cnt_q <= cnt_d;
            gnt_q <= gnt_d;
            ov_q <= issue;
            ol_q <= issue && last;
            oid_q <= issue ? id_q : oid_q;
        end
    end
    assign gnt = gnt_q;
    assign fifo_rd_en = issue;
    assign out_valid = ov_q;
    assign out_last = ol_q;
    assign out_id = oid_q;
    assign out_data = ov_q ? fifo_rd_data : '0;
    assign busy = state_q != IDLE;
endmodule

// File: tb/tb_fifo_rd_arb.sv
// tb_fifo_rd_arb: directed scenarios plus randomized traffic checked every cycle against a burst-level reference model.
module tb_fifo_rd_arb;
    logic rdclk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] req = '0;
    logic [31:0] req_len = '0;
    logic [3:0] gnt;
    logic fifo_rd_en;
    logic [15:0] fifo_rd_data = '0;
    logic fifo_rd_empty = 1'b1;
    logic [15:0] out_data;
    logic out_valid;
    logic [1:0] out_id;
    logic out_last;
    logic busy;
    int checks = 0;
    int failures = 0;
    int s_pops = 0;
    int nv = 0, nl = 0, last_at = 0;

    fifo_rd_arb dut (
        .rdclk(rdclk), .rst_n(rst_n), .req(req), .req_len(req_len), .gnt(gnt),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty),
        .out_data(out_data), .out_valid(out_valid), .out_id(out_id), .out_last(out_last), .busy(busy)
    );

    always #5 rdclk = ~rdclk;

    function automatic logic [15:0] dgen(input int n);
        return 16'(n * 40503 + 7);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // FIFO stub: registered read data, one new word per accepted read
    always @(posedge rdclk) begin
        if (fifo_rd_en) begin
            fifo_rd_data <= dgen(s_pops);
            s_pops <= s_pops + 1;
        end
    end

    // reference model: a burst is an owner plus beats left; a finished burst holds its grant one extra cycle
    bit started = 0, m_active = 0, m_tail = 0, e_valid = 0, e_last = 0;
    int m_owner = 0, m_left = 0, m_ptr = 0, m_pops = 0, e_id = 0, ln = 0;
    logic [15:0] e_data = '0;
    always @(posedge rdclk) begin
        if (!rst_n) begin
            if (m_active && !m_tail && !fifo_rd_empty) m_pops++;
            started = 1; m_active = 0; m_tail = 0; m_left = 0; m_ptr = 0;
            e_valid = 0; e_last = 0; e_id = 0; e_data = '0;
        end else begin
            e_valid = 0; e_last = 0;
            if (m_active && m_tail) begin
                m_active = 0; m_tail = 0;
            end else if (m_active) begin
                if (!fifo_rd_empty) begin
                    e_valid = 1; e_id = m_owner; e_data = dgen(m_pops); m_pops++;
                    m_left--; e_last = (m_left == 0); m_tail = (m_left == 0);
                end
            end else if (req != 0) begin
                for (int k = 0; k < 4; k++)
                    if (req[(m_ptr + k) % 4] && !m_active) begin
                        m_owner = (m_ptr + k) % 4; m_active = 1;
                    end
                ln = int'(req_len[m_owner*8 +: 8]);
                m_left = (ln == 0) ? 1 : ln;
                m_ptr = (m_owner + 1) % 4;
            end
        end
    end

    always @(negedge rdclk) begin
        if (started) begin
            chk("gnt", 32'(gnt), m_active ? 32'(1 << m_owner) : 32'd0);
            chk("busy", 32'(busy), 32'(m_active));
            chk("rd_en", 32'(fifo_rd_en), 32'(m_active && !m_tail && !fifo_rd_empty));
            chk("out_valid", 32'(out_valid), 32'(e_valid));
            chk("out_last", 32'(out_last), 32'(e_last));
            if (e_valid) begin
                chk("out_id", 32'(out_id), 32'(e_id));
                chk("out_data", 32'(out_data), 32'(e_data));
            end
            if (out_valid === 1'b1) begin
                nv++;
                if (out_last) begin nl++; last_at = nv; end
            end
        end
    end

    task automatic next_cyc();
        @(posedge rdclk); #2;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin next_cyc(); n++; end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; next_cyc(); rst_n = 1'b1;
    endtask

    task automatic clr_cnt();
        nv = 0; nl = 0; last_at = 0;
    endtask

    initial begin
        logic [3:0] prev_g;
        int g_id[$], g_cyc[$];
        repeat (3) next_cyc();
        rst_n = 1'b1;
        // single burst: requester 1, length 3
        req_len[15:8] = 8'd3; fifo_rd_empty = 1'b0; req = 4'b0010;
        for (int c = 0; c < 7; c++) begin
            @(negedge rdclk);
            chk("sb_gnt", 32'(gnt), (c >= 1 && c <= 4) ? 32'h2 : 32'h0);
            chk("sb_rden", 32'(fifo_rd_en), 32'(c >= 1 && c <= 3));
            chk("sb_valid", 32'(out_valid), 32'(c >= 2 && c <= 4));
            chk("sb_last", 32'(out_last), 32'(c == 4));
            if (c >= 2 && c <= 4) chk("sb_id", 32'(out_id), 32'd1);
            next_cyc();
            if (c == 0) begin req = '0; req_len[15:8] = 8'd7; end
        end
        // round robin from a fresh pointer
        do_reset();
        req_len = {4{8'd1}}; req = 4'hf; prev_g = '0;
        for (int c = 0; c < 16; c++) begin
            @(negedge rdclk);
            if (gnt != 0 && prev_g == 0)
                for (int i = 0; i < 4; i++) if (gnt[i]) begin g_id.push_back(i); g_cyc.push_back(c); end
            prev_g = gnt;
            next_cyc();
        end
        req = '0; wait_idle(20);
        chk("rr_count", 32'(g_id.size() >= 5), 32'd1);
        if (g_id.size() >= 5)
            for (int i = 0; i < 5; i++) begin
                chk("rr_order", 32'(g_id[i]), 32'(i % 4));
                if (i > 0) chk("rr_spacing", 32'(g_cyc[i] - g_cyc[i-1]), 32'd3);
            end
        // empty stall mid-burst
        clr_cnt(); req_len[7:0] = 8'd4; fifo_rd_empty = 1'b0; req = 4'b0001;
        for (int c = 0; c < 10; c++) begin
            @(negedge rdclk);
            if (c == 3 || c == 4) chk("st_rden", 32'(fifo_rd_en), 32'd0);
            next_cyc();
            fifo_rd_empty = (c + 1 == 3 || c + 1 == 4);
            if (c == 0) req = '0;
        end
        wait_idle(20);
        chk("st_beats", 32'(nv), 32'd4); chk("st_lasts", 32'(nl), 32'd1); chk("st_last_at", 32'(last_at), 32'd4);
        // zero length is one beat
        clr_cnt(); req_len[23:16] = 8'd0; req = 4'b0100;
        next_cyc(); req = '0; wait_idle(20);
        chk("z_beats", 32'(nv), 32'd1); chk("z_lasts", 32'(nl), 32'd1); chk("z_last_at", 32'(last_at), 32'd1);
        // maximum length
        clr_cnt(); req_len[31:24] = 8'd255; req = 4'b1000;
        next_cyc(); req = '0; wait_idle(400);
        chk("max_beats", 32'(nv), 32'd255); chk("max_lasts", 32'(nl), 32'd1); chk("max_last_at", 32'(last_at), 32'd255);
        // reset at beat 2 of 5
        req_len[15:8] = 8'd5; req = 4'b0010;
        next_cyc(); req = '0;
        next_cyc(); rst_n = 1'b0;
        next_cyc(); rst_n = 1'b1; req = 4'b0001; req_len[7:0] = 8'd1;
        @(negedge rdclk);
        chk("rst_gnt", 32'(gnt), 32'd0); chk("rst_rden", 32'(fifo_rd_en), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0); chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_id", 32'(out_id), 32'd0); chk("rst_data", 32'(out_data), 32'd0); chk("rst_busy", 32'(busy), 32'd0);
        next_cyc(); req = '0;
        @(negedge rdclk);
        chk("rst_regrant", 32'(gnt), 32'h1);
        wait_idle(20);
        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            next_cyc();
            req = 4'($urandom);
            for (int i = 0; i < 4; i++) req_len[i*8 +: 8] = 8'($urandom_range(0, 6));
            fifo_rd_empty = ($urandom_range(0, 9) < 3);
            rst_n = ($urandom_range(0, 199) != 0);
        end
        next_cyc();
        rst_n = 1'b1; req = '0; fifo_rd_empty = 1'b0;
        wait_idle(600);
        next_cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
